rs_issue_queue: RTL and testbench
=================================

Name: rs_issue_queue

Overview:
Unified reservation station. It receives renamed disp_packet_t instructions from dispatch, holds them until both source pregs are ready, and issues the oldest ready entry as an exec_packet_t toward register read and the FUs. It is the consumer of the dispatch packet and the producer of the execute packet. Wakeup comes from the NUM_FUS writeback tag buses.

Parameters:
RS_ENTRIES, 4 (CORE_PKG), number of queue slots
NUM_FUS, 4 (CORE_PKG), number of wakeup tag buses
NUM_PREGS, 64 (CORE_PKG), physical register count; tag width is clog2(NUM_PREGS)
ROB_ENTRIES, 16 (CORE_PKG), ROB size; rob index width is clog2(ROB_ENTRIES)

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  mispredict/exception squash; clears all entries
disp_valid  in  1  dispatch offers a packet
disp_ready  out  1  a slot is free
disp_pkt  in  disp_packet_t  renamed instruction
disp_rob_idx  in  clog2(ROB_ENTRIES)  ROB slot allocated to the instruction
disp_src1_rdy  in  1  src1 preg is already ready (busy table)
disp_src2_rdy  in  1  src2 preg is already ready; dispatch drives 1 when the instruction has no src2
wb_valid  in  NUM_FUS  per-FU wakeup strobe
wb_preg  in  NUM_FUS*clog2(NUM_PREGS)  per-FU destination tag; FU i occupies slice i
iss_valid  out  1  iss_pkt is valid
iss_ready  in  1  downstream accepts
iss_pkt  out  exec_packet_t  issued instruction
rs_count  out  clog2(RS_ENTRIES)+1  occupied entries

Behaviour:
- Only the synchronous, active-high rst is used; there is no asynchronous reset.
- Reset: every entry valid=0 and the age matrix is cleared. Outputs after reset: disp_ready=1, iss_valid=0, rs_count=0, iss_pkt all zero.
- Dispatch handshake:
  - disp_ready = (rs_count != RS_ENTRIES) && !flush.
  - The ready value is computed from registered state only; a same-cycle issue does not free a slot for dispatch.
  - On disp_valid&&disp_ready, the packet is written into the lowest-index free slot.
  - The entry is marked older than every currently valid entry.
  - The stored src_rdy bits are disp_srcN_rdy OR'd with a same-cycle wakeup match.
- Wakeup:
  - For each valid entry and each FU i, wb_valid[i] && wb_preg[i]==src1_preg sets src1_rdy.
  - The same rule applied to src2_preg sets src2_rdy.
  - Ready bits are sticky until the entry is freed.
- Select:
  - An entry is eligible when valid && src1_rdy && src2_rdy.
  - The pick is the eligible entry that no other eligible entry is older than, taken from the age matrix.
  - The selection is combinational from registered state.
- Issue:
  - iss_valid = any eligible && !flush.
  - iss_pkt is built from the selected entry:
    - opcode, dst_areg, dst_preg, src1_preg, src2_preg, imm_val, instr_valid, pc and br_taken are copied.
    - rob_entry_idx is the stored ROB index.
    - src1_val and src2_val are driven 0; register read fills them.
    - alu_en = 1 unless opcode is LW, SW or INVALID.
  - When iss_valid is 0, iss_pkt is driven all zero.
  - On iss_valid&&iss_ready, the selected entry is freed at the edge.
  - iss_pkt and the selection must hold stable while iss_valid&&!iss_ready. The oldest-first pick stays stable under stall unless an older entry wakes up; that re-pick is permitted because nothing was accepted.
- Latency:
  - A packet dispatched in cycle N with both sources ready gives iss_valid in N+1.
  - A wakeup in cycle N makes the entry eligible in N+1.
  - There is no same-cycle dispatch-to-issue bypass.
- Simultaneous events:
  - Dispatch and issue in the same cycle: both take effect and rs_count is unchanged.
  - Dispatch into a full queue with a same-cycle issue is rejected (disp_ready=0).
- flush:
  - All entries are invalidated at the edge.
  - Dispatch is ignored in the flush cycle, and iss_valid is 0 in that cycle.
  - rs_count=0 in the next cycle.
- rst asserted mid-operation behaves identically to flush and also clears the age matrix.
- rs_count equals the popcount of the valid bits and never exceeds RS_ENTRIES.

Decomposition:
- CORE_PKG gains rs_entry_t, a packed struct containing:
  - disp_packet_t pkt
  - rob_idx
  - src1_rdy, src2_rdy
  - valid
- CORE_PKG also gains constant RS_IDX_W = $clog2(RS_ENTRIES).
- Sub-module rs_age_select:
  - Owns the RS_ENTRIES×RS_ENTRIES age matrix.
  - Inputs: alloc one-hot, free one-hot, eligible vector.
  - Outputs: oldest-eligible one-hot plus an any-eligible bit.
- rs_issue_queue keeps the entry storage, wakeup compare, handshakes and exec_packet_t formatting.

Test Plan:
- Reset, then dispatch ADD dst_preg=10 with src1=3 and src2=4 both ready, rob_idx=5, iss_ready=1 → the next cycle has iss_valid=1, iss_pkt.rob_entry_idx=5, iss_pkt.alu_en=1, then rs_count returns to 0.
- Dispatch LW(src1=7 not ready), then ADDI(src1=2 ready); pulse wb_valid[2] with wb_preg[2]=7 → ADDI issues first; LW issues the cycle after the wakeup with alu_en=0.
- Fill 4 entries with src1=20 not ready → disp_ready=0 and rs_count=4. Broadcast preg 20 on FU0 → the entries issue oldest-first over 4 cycles in dispatch order, and disp_ready=1 after the first accept.
- Hold iss_ready=0 for 3 cycles with 2 ready entries → iss_pkt stays stable on the older entry, no entry is freed, and rs_count stays 2.
- Dispatch with src2=9 not ready in the same cycle as wb_valid[1] with wb_preg[1]=9 → the entry issues the next cycle, so no wakeup is lost.
- With 3 entries held, assert flush while disp_valid=1 → the next cycle shows rs_count=0 and iss_valid=0, and the flushed dispatch is not captured.

Source files
------------

// File: rtl/rs_issue_queue_pkg.sv
// rs_issue_queue_pkg
// Shared types and constants for the unified reservation station.
//   - core sizing constants (entries, FU count, preg/ROB sizes) and derived widths
//   - opcode_t, disp_packet_t (from dispatch), exec_packet_t (toward register read)
//   - rs_entry_t: one reservation-station slot
//   - helpers: wakeup tag match, ALU-enable decode, popcount
package rs_issue_queue_pkg;

    localparam int RS_ENTRIES  = 4;
    localparam int NUM_FUS     = 4;
    localparam int NUM_PREGS   = 64;
    localparam int ROB_ENTRIES = 16;

    localparam int TAG_W     = $clog2(NUM_PREGS);
    localparam int ROB_IDX_W = $clog2(ROB_ENTRIES);
    localparam int RS_IDX_W  = $clog2(RS_ENTRIES);
    localparam int CNT_W     = RS_IDX_W + 1;

    typedef enum logic [3:0] {
        OP_INVALID = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_ADDI    = 4'd5,
        OP_LW      = 4'd6,
        OP_SW      = 4'd7,
        OP_BEQ     = 4'd8
    } opcode_t;

    typedef struct packed {
        opcode_t           opcode;
        logic [4:0]        dst_areg;
        logic [TAG_W-1:0]  dst_preg;
        logic [TAG_W-1:0]  src1_preg;
        logic [TAG_W-1:0]  src2_preg;
        logic [31:0]       imm_val;
        logic              instr_valid;
        logic [31:0]       pc;
        logic              br_taken;
    } disp_packet_t;

    typedef struct packed {
        opcode_t               opcode;
        logic [4:0]            dst_areg;
        logic [TAG_W-1:0]      dst_preg;
        logic [TAG_W-1:0]      src1_preg;
        logic [TAG_W-1:0]      src2_preg;
        logic [31:0]           imm_val;
        logic                  instr_valid;
        logic [31:0]           pc;
        logic                  br_taken;
        logic [ROB_IDX_W-1:0]  rob_entry_idx;
        logic [31:0]           src1_val;
        logic [31:0]           src2_val;
        logic                  alu_en;
    } exec_packet_t;

    typedef struct packed {
        disp_packet_t          pkt;
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic                  src1_rdy;
        logic                  src2_rdy;
        logic                  valid;
    } rs_entry_t;

    // True when any strobed writeback bus carries the given tag.
    function automatic logic wake_match(input logic [TAG_W-1:0]         tag,
                                        input logic [NUM_FUS-1:0]       wb_v,
                                        input logic [NUM_FUS*TAG_W-1:0] wb_t);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (wb_v[f] && (wb_t[f*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Memory ops and invalid slots do not use the ALU.
    function automatic logic is_alu_op(input opcode_t op);
        logic en;
        case (op)
            OP_LW, OP_SW, OP_INVALID: en = 1'b0;
            default:                  en = 1'b1;
        endcase
        return en;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [RS_ENTRIES-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < RS_ENTRIES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rs_issue_queue_age_select.sv
// rs_issue_queue_age_select (module rs_age_select)
// Age matrix and oldest-eligible picker for the reservation station.
// r_older[i][j] = 1 means entry i was allocated before entry j.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears matrix)
//   alloc_oh        : one-hot slot being written this edge
//   free_oh         : one-hot slot being released this edge
//   eligible        : per-slot ready-to-issue vector
//   oldest_oh       : one-hot oldest eligible slot (zero when none)
//   any_eligible    : at least one slot is eligible
module rs_age_select
    import rs_issue_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RS_ENTRIES-1:0] alloc_oh,
    input  logic [RS_ENTRIES-1:0] free_oh,
    input  logic [RS_ENTRIES-1:0] eligible,
    output logic [RS_ENTRIES-1:0] oldest_oh,
    output logic                  any_eligible
);

    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] r_older;

    // Age matrix update: a new entry is younger than every other slot.
    // Stale bits against free slots are harmless because a slot's row is
    // cleared and its column set again when it is next allocated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_older <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (i == j) begin
                        r_older[i][j] <= 1'b0;
                    end else if (alloc_oh[i]) begin
                        r_older[i][j] <= 1'b0;
                    end else if (alloc_oh[j]) begin
                        r_older[i][j] <= 1'b1;
                    end else if (free_oh[i] || free_oh[j]) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Pick the eligible slot that no other eligible slot is older than.
    always_comb begin
        oldest_oh = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            oldest_oh[i] = eligible[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if ((j != i) && eligible[j] && r_older[j][i]) begin
                    oldest_oh[i] = 1'b0;
                end
            end
        end
        any_eligible = |eligible;
    end

endmodule

// File: rtl/rs_issue_queue.sv
// rs_issue_queue
// Unified reservation station: holds renamed instructions until both source
// pregs are ready and issues the oldest ready one.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   flush                       : squash all entries, block dispatch/issue this cycle
//   disp_valid/disp_ready       : dispatch handshake
//   disp_pkt, disp_rob_idx      : renamed instruction and its ROB slot
//   disp_src1_rdy/disp_src2_rdy : source readiness from the busy table
//   wb_valid, wb_preg           : per-FU wakeup strobes and tags (FU i = slice i)
//   iss_valid/iss_ready         : issue handshake
//   iss_pkt                     : issued instruction (zero when not valid)
//   rs_count                    : number of occupied slots
module rs_issue_queue
    import rs_issue_queue_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  disp_packet_t               disp_pkt,
    input  logic [ROB_IDX_W-1:0]       disp_rob_idx,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [NUM_FUS-1:0]         wb_valid,
    input  logic [NUM_FUS*TAG_W-1:0]   wb_preg,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output exec_packet_t               iss_pkt,
    output logic [CNT_W-1:0]           rs_count
);

    rs_entry_t               r_entries [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]   w_valid;
    logic [RS_ENTRIES-1:0]   w_eligible;
    logic [RS_ENTRIES-1:0]   w_wake1;
    logic [RS_ENTRIES-1:0]   w_wake2;
    logic [RS_ENTRIES-1:0]   w_alloc_oh;
    logic [RS_ENTRIES-1:0]   w_alloc_fire_oh;
    logic [RS_ENTRIES-1:0]   w_free_oh;
    logic [RS_ENTRIES-1:0]   w_sel_oh;
    logic                    w_any_elig;
    logic                    w_found;
    logic                    w_disp_fire;
    logic                    w_iss_fire;
    logic                    w_disp_wake1;
    logic                    w_disp_wake2;
    rs_entry_t               w_sel_entry;

    // Per-slot status, wakeup matches and lowest free slot.
    always_comb begin
        w_valid    = '0;
        w_eligible = '0;
        w_wake1    = '0;
        w_wake2    = '0;
        w_alloc_oh = '0;
        w_found    = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_valid[i]    = r_entries[i].valid;
            w_eligible[i] = r_entries[i].valid && r_entries[i].src1_rdy && r_entries[i].src2_rdy;
            w_wake1[i]    = wake_match(r_entries[i].pkt.src1_preg, wb_valid, wb_preg);
            w_wake2[i]    = wake_match(r_entries[i].pkt.src2_preg, wb_valid, wb_preg);
            if (!r_entries[i].valid && !w_found) begin
                w_alloc_oh[i] = 1'b1;
                w_found       = 1'b1;
            end else begin
                w_alloc_oh[i] = 1'b0;
            end
        end
        w_disp_wake1 = wake_match(disp_pkt.src1_preg, wb_valid, wb_preg);
        w_disp_wake2 = wake_match(disp_pkt.src2_preg, wb_valid, wb_preg);
    end

    // Handshakes from registered state only; a same-cycle issue does not free a slot.
    always_comb begin
        rs_count        = popcount(w_valid);
        disp_ready      = (rs_count != CNT_W'(RS_ENTRIES)) && !flush;
        iss_valid       = w_any_elig && !flush;
        w_disp_fire     = disp_valid && disp_ready;
        w_iss_fire      = iss_valid && iss_ready;
        w_alloc_fire_oh = w_disp_fire ? w_alloc_oh : '0;
        w_free_oh       = w_iss_fire ? w_sel_oh : '0;
    end

    rs_age_select u_age (
        .clk          (clk),
        .rst          (rst),
        .alloc_oh     (w_alloc_fire_oh),
        .free_oh      (w_free_oh),
        .eligible     (w_eligible),
        .oldest_oh    (w_sel_oh),
        .any_eligible (w_any_elig)
    );

    // Selected-entry mux and execute packet formatting.
    always_comb begin
        w_sel_entry = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_entry = w_sel_entry | r_entries[i];
            end
        end
        iss_pkt = '0;
        if (iss_valid) begin
            iss_pkt.opcode        = w_sel_entry.pkt.opcode;
            iss_pkt.dst_areg      = w_sel_entry.pkt.dst_areg;
            iss_pkt.dst_preg      = w_sel_entry.pkt.dst_preg;
            iss_pkt.src1_preg     = w_sel_entry.pkt.src1_preg;
            iss_pkt.src2_preg     = w_sel_entry.pkt.src2_preg;
            iss_pkt.imm_val       = w_sel_entry.pkt.imm_val;
            iss_pkt.instr_valid   = w_sel_entry.pkt.instr_valid;
            iss_pkt.pc            = w_sel_entry.pkt.pc;
            iss_pkt.br_taken      = w_sel_entry.pkt.br_taken;
            iss_pkt.rob_entry_idx = w_sel_entry.rob_idx;
            iss_pkt.src1_val      = 32'd0;
            iss_pkt.src2_val      = 32'd0;
            iss_pkt.alu_en        = is_alu_op(w_sel_entry.pkt.opcode);
        end else begin
            iss_pkt = '0;
        end
    end

    // Entry storage: allocate, free on accepted issue, accumulate sticky wakeups.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_alloc_fire_oh[i]) begin
                    r_entries[i].pkt      <= disp_pkt;
                    r_entries[i].rob_idx  <= disp_rob_idx;
                    r_entries[i].src1_rdy <= disp_src1_rdy || w_disp_wake1;
                    r_entries[i].src2_rdy <= disp_src2_rdy || w_disp_wake2;
                    r_entries[i].valid    <= 1'b1;
                end else if (w_free_oh[i]) begin
                    r_entries[i] <= '0;
                end else if (r_entries[i].valid) begin
                    r_entries[i].src1_rdy <= r_entries[i].src1_rdy || w_wake1[i];
                    r_entries[i].src2_rdy <= r_entries[i].src2_rdy || w_wake2[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Testbench for rs_issue_queue: directed dispatch/wakeup/stall/flush vectors,
// expected issues queued in order and checked by an independent monitor.
module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     disp_valid;
    logic                     disp_ready;
    disp_packet_t             disp_pkt;
    logic [ROB_IDX_W-1:0]     disp_rob_idx;
    logic                     disp_src1_rdy;
    logic                     disp_src2_rdy;
    logic [NUM_FUS-1:0]       wb_valid;
    logic [NUM_FUS*TAG_W-1:0] wb_preg;
    logic                     iss_valid;
    logic                     iss_ready;
    exec_packet_t             iss_pkt;
    logic [CNT_W-1:0]         rs_count;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob;
        logic [TAG_W-1:0]     dst;
        opcode_t              op;
        logic                 alu;
        logic [31:0]          pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rs_issue_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_pkt      (disp_pkt),
        .disp_rob_idx  (disp_rob_idx),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .wb_valid      (wb_valid),
        .wb_preg       (wb_preg),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_pkt       (iss_pkt),
        .rs_count      (rs_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one dispatch offer (caller advances the clock).
    task automatic drive_disp(input opcode_t op, input logic [TAG_W-1:0] dst,
                              input logic [TAG_W-1:0] s1, input logic r1,
                              input logic [TAG_W-1:0] s2, input logic r2,
                              input logic [ROB_IDX_W-1:0] rob);
        disp_valid            = 1'b1;
        disp_pkt              = '0;
        disp_pkt.opcode       = op;
        disp_pkt.dst_areg     = 5'(dst);
        disp_pkt.dst_preg     = dst;
        disp_pkt.src1_preg    = s1;
        disp_pkt.src2_preg    = s2;
        disp_pkt.imm_val      = 32'd16;
        disp_pkt.instr_valid  = 1'b1;
        disp_pkt.pc           = 32'h100 + {28'd0, rob} * 32'd4;
        disp_rob_idx          = rob;
        disp_src1_rdy         = r1;
        disp_src2_rdy         = r2;
    endtask

    task automatic expect_iss(input opcode_t op, input logic [TAG_W-1:0] dst,
                              input logic [ROB_IDX_W-1:0] rob, input logic alu);
        exp_t e;
        e.rob = rob;
        e.dst = dst;
        e.op  = op;
        e.alu = alu;
        e.pc  = 32'h100 + {28'd0, rob} * 32'd4;
        sb.push_back(e);
    endtask

    // Monitor: every accepted issue must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", {60'd0, iss_pkt.rob_entry_idx}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("iss_rob", 64'(iss_pkt.rob_entry_idx), 64'(e.rob));
                check("iss_dst", 64'(iss_pkt.dst_preg), 64'(e.dst));
                check("iss_op", 64'(iss_pkt.opcode), 64'(e.op));
                check("iss_alu_en", 64'(iss_pkt.alu_en), 64'(e.alu));
                check("iss_pc", 64'(iss_pkt.pc), 64'(e.pc));
                check("iss_src_vals", {iss_pkt.src1_val, iss_pkt.src2_val}, 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_pkt = '0;
        disp_rob_idx = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        wb_valid = '0; wb_preg = '0; iss_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_count", 64'(rs_count), 64'd0);
        check("rst_pkt_zero", 64'(iss_pkt == '0), 64'd1);

        // 1: ready ADD issues the cycle after dispatch
        tick();
        drive_disp(OP_ADD, 6'd10, 6'd3, 1'b1, 6'd4, 1'b1, 4'd5);
        expect_iss(OP_ADD, 6'd10, 4'd5, 1'b1);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t1_latency", 64'(iss_valid), 64'd1);
        tick();
        @(negedge clk);
        check("t1_count", 64'(rs_count), 64'd0);

        // 2: LW waits on preg 7, younger ADDI issues first
        tick();
        drive_disp(OP_LW, 6'd11, 6'd7, 1'b0, 6'd0, 1'b1, 4'd1);
        expect_iss(OP_ADDI, 6'd12, 4'd2, 1'b1);
        expect_iss(OP_LW, 6'd11, 4'd1, 1'b0);
        tick();
        drive_disp(OP_ADDI, 6'd12, 6'd2, 1'b1, 6'd0, 1'b1, 4'd2);
        tick();
        disp_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t2_lw_waiting", 64'(iss_valid), 64'd0);
        check("t2_count", 64'(rs_count), 64'd1);
        wb_valid = 4'b0100;
        wb_preg[2*TAG_W +: TAG_W] = 6'd7;
        tick();
        wb_valid = '0;
        @(negedge clk);
        check("t2_lw_woken", 64'(iss_valid), 64'd1);
        check("t2_lw_alu_en", 64'(iss_pkt.alu_en), 64'd0);
        tick();

        // 3: fill with entries waiting on preg 20, then broadcast
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(OP_SUB, 6'(30 + k), 6'd20, 1'b0, 6'd1, 1'b1, 4'(8 + k));
            expect_iss(OP_SUB, 6'(30 + k), 4'(8 + k), 1'b1);
            tick();
        end
        disp_valid = 1'b0;
        @(negedge clk);
        check("t3_full_ready", 64'(disp_ready), 64'd0);
        check("t3_full_count", 64'(rs_count), 64'd4);
        iss_ready = 1'b1;
        wb_valid = 4'b0001;
        wb_preg = '0;
        wb_preg[0 +: TAG_W] = 6'd20;
        tick();
        wb_valid = '0;
        @(negedge clk);
        check("t3_first_ready", 64'(disp_ready), 64'd0);
        tick();
        @(negedge clk);
        check("t3_after_accept_ready", 64'(disp_ready), 64'd1);
        check("t3_after_accept_count", 64'(rs_count), 64'd3);
        tick(); tick(); tick();
        @(negedge clk);
        check("t3_drained", 64'(rs_count), 64'd0);

        // 4: stall with two ready entries
        iss_ready = 1'b0;
        drive_disp(OP_SUB, 6'd40, 6'd1, 1'b1, 6'd2, 1'b1, 4'd3);
        expect_iss(OP_SUB, 6'd40, 4'd3, 1'b1);
        tick();
        drive_disp(OP_AND, 6'd41, 6'd1, 1'b1, 6'd2, 1'b1, 4'd4);
        expect_iss(OP_AND, 6'd41, 4'd4, 1'b1);
        tick();
        disp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall_rob", 64'(iss_pkt.rob_entry_idx), 64'd3);
            check("t4_stall_dst", 64'(iss_pkt.dst_preg), 64'd40);
            check("t4_stall_count", 64'(rs_count), 64'd2);
            tick();
        end
        iss_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("t4_drained", 64'(rs_count), 64'd0);

        // 5: wakeup in the dispatch cycle is not lost
        drive_disp(OP_OR, 6'd42, 6'd1, 1'b1, 6'd9, 1'b0, 4'd6);
        expect_iss(OP_OR, 6'd42, 4'd6, 1'b1);
        wb_valid = 4'b0010;
        wb_preg = '0;
        wb_preg[1*TAG_W +: TAG_W] = 6'd9;
        tick();
        disp_valid = 1'b0;
        wb_valid = '0;
        @(negedge clk);
        check("t5_same_cycle_wake", 64'(iss_valid), 64'd1);
        tick();
        @(negedge clk);
        check("t5_drained", 64'(rs_count), 64'd0);

        // 6: flush with three held entries and a concurrent dispatch
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_disp(OP_ADD, 6'(50 + k), 6'd1, 1'b1, 6'd2, 1'b1, 4'(12 + k));
            tick();
        end
        drive_disp(OP_ADD, 6'd55, 6'd1, 1'b1, 6'd2, 1'b1, 4'd15);
        flush = 1'b1;
        @(negedge clk);
        check("t6_flush_disp_ready", 64'(disp_ready), 64'd0);
        check("t6_flush_iss_valid", 64'(iss_valid), 64'd0);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        @(negedge clk);
        check("t6_count", 64'(rs_count), 64'd0);
        check("t6_iss_valid", 64'(iss_valid), 64'd0);
        iss_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("t6_not_captured", 64'(rs_count), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
